// File: rtl/hsv_core_ctrlstatus_regs_pkg.sv
// Shared CSR numbering and decode helpers for the ctrlstatus counter block.
package hsv_core_ctrlstatus_regs_pkg;

  typedef logic [11:0] csr_num_t;

  localparam csr_num_t CSR_MCYCLE        = 12'hB00;
  localparam csr_num_t CSR_MCYCLEH       = 12'hB80;
  localparam csr_num_t CSR_MINSTRET      = 12'hB02;
  localparam csr_num_t CSR_MINSTRETH     = 12'hB82;
  localparam csr_num_t CSR_CYCLE         = 12'hC00;
  localparam csr_num_t CSR_CYCLEH        = 12'hC80;
  localparam csr_num_t CSR_INSTRET       = 12'hC02;
  localparam csr_num_t CSR_INSTRETH      = 12'hC82;
  localparam csr_num_t CSR_MCOUNTINHIBIT = 12'h320;

  localparam int MCOUNTINHIBIT_CY = 0;
  localparam int MCOUNTINHIBIT_IR = 2;

  // Machine counters and their user shadows decode to the same storage select.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_INS_LO,
    SEL_INS_HI,
    SEL_INHIBIT
  } csr_sel_e;

  function automatic logic csr_is_read_only(csr_num_t num);
    return num[11:10] == 2'b11;
  endfunction

  function automatic csr_sel_e csr_decode(csr_num_t num);
    case (num)
      CSR_MCYCLE,    CSR_CYCLE:    return SEL_CYC_LO;
      CSR_MCYCLEH,   CSR_CYCLEH:   return SEL_CYC_HI;
      CSR_MINSTRET,  CSR_INSTRET:  return SEL_INS_LO;
      CSR_MINSTRETH, CSR_INSTRETH: return SEL_INS_HI;
      CSR_MCOUNTINHIBIT:           return SEL_INHIBIT;
      default:                     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hsv_core_ctrlstatus_counter64.sv
// One 64-bit event counter with half-word bit-masked writes; a write in any
// half suppresses that cycle's increment entirely.
module hsv_core_ctrlstatus_counter64 (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [31:0] wr_biten,
  output logic [63:0] value
);

  logic [63:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (wr_lo) value_d[31:0]  = (value_q[31:0]  & ~wr_biten) | (wr_data & wr_biten);
    if (wr_hi) value_d[63:32] = (value_q[63:32] & ~wr_biten) | (wr_data & wr_biten);
    if (!wr_lo && !wr_hi && inc) value_d = value_q + 64'd1;
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/hsv_core_ctrlstatus_counters.sv
// mcycle/minstret CSR responder on the ctrlstatus register bus.
// Define HSV_CTRLSTATUS_COUNTERS_INHIBIT_EN to implement mcountinhibit.
module hsv_core_ctrlstatus_counters
  import hsv_core_ctrlstatus_regs_pkg::*;
(
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        regs_req,
  input  logic        regs_req_is_wr,
  input  logic [15:0] regs_addr,
  input  logic [31:0] regs_wr_data,
  input  logic [31:0] regs_wr_biten,
  output logic        regs_req_stall_rd,
  output logic        regs_req_stall_wr,
  output logic        regs_rd_ack,
  output logic        regs_rd_err,
  output logic [31:0] regs_rd_data,
  output logic        regs_wr_ack,
  output logic        regs_wr_err,
  input  logic        retire
);

  csr_num_t    csr_num;
  csr_sel_e    sel;
  logic        stall, rd_acc, wr_acc, rd_ok, wr_ok, wr_en;
  logic        inh_cy, inh_ir;
  logic [31:0] rd_mux;
  logic [63:0] mcycle, minstret;

  logic        rd_ack_d, rd_ack_q, rd_err_d, rd_err_q;
  logic        wr_ack_d, wr_ack_q, wr_err_d, wr_err_q;
  logic [31:0] rd_data_d, rd_data_q;

  assign csr_num = regs_addr[15:4];
  assign sel     = csr_decode(csr_num);
  // A response in flight blocks the next acceptance, so at most one is outstanding.
  assign stall   = rd_ack_q | wr_ack_q;
  assign rd_acc  = regs_req & ~regs_req_is_wr & ~stall;
  assign wr_acc  = regs_req &  regs_req_is_wr & ~stall;
  assign rd_ok   = (regs_addr[3:0] == 4'd0) && (sel != SEL_NONE);
  assign wr_ok   = rd_ok && !csr_is_read_only(csr_num);
  assign wr_en   = wr_acc & wr_ok;

`ifdef HSV_CTRLSTATUS_COUNTERS_INHIBIT_EN
  logic inh_cy_d, inh_cy_q, inh_ir_d, inh_ir_q;

  always_comb begin
    inh_cy_d = inh_cy_q;
    inh_ir_d = inh_ir_q;
    if (wr_en && sel == SEL_INHIBIT) begin
      inh_cy_d = (inh_cy_q & ~regs_wr_biten[MCOUNTINHIBIT_CY]) |
                 (regs_wr_data[MCOUNTINHIBIT_CY] & regs_wr_biten[MCOUNTINHIBIT_CY]);
      inh_ir_d = (inh_ir_q & ~regs_wr_biten[MCOUNTINHIBIT_IR]) |
                 (regs_wr_data[MCOUNTINHIBIT_IR] & regs_wr_biten[MCOUNTINHIBIT_IR]);
    end
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      inh_cy_q <= 1'b0;
      inh_ir_q <= 1'b0;
    end else begin
      inh_cy_q <= inh_cy_d;
      inh_ir_q <= inh_ir_d;
    end
  end

  assign inh_cy = inh_cy_q;
  assign inh_ir = inh_ir_q;
`else
  assign inh_cy = 1'b0;
  assign inh_ir = 1'b0;
`endif

  hsv_core_ctrlstatus_counter64 u_mcycle (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .inc      (~inh_cy),
    .wr_lo    (wr_en && sel == SEL_CYC_LO),
    .wr_hi    (wr_en && sel == SEL_CYC_HI),
    .wr_data  (regs_wr_data),
    .wr_biten (regs_wr_biten),
    .value    (mcycle)
  );

  hsv_core_ctrlstatus_counter64 u_minstret (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .inc      (retire & ~inh_ir),
    .wr_lo    (wr_en && sel == SEL_INS_LO),
    .wr_hi    (wr_en && sel == SEL_INS_HI),
    .wr_data  (regs_wr_data),
    .wr_biten (regs_wr_biten),
    .value    (minstret)
  );

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_CYC_LO:  rd_mux = mcycle[31:0];
      SEL_CYC_HI:  rd_mux = mcycle[63:32];
      SEL_INS_LO:  rd_mux = minstret[31:0];
      SEL_INS_HI:  rd_mux = minstret[63:32];
      SEL_INHIBIT: begin
        rd_mux[MCOUNTINHIBIT_CY] = inh_cy;
        rd_mux[MCOUNTINHIBIT_IR] = inh_ir;
      end
      default:     rd_mux = '0;
    endcase
  end

  always_comb begin
    rd_ack_d  = rd_acc;
    rd_err_d  = rd_acc & ~rd_ok;
    rd_data_d = (rd_acc && rd_ok) ? rd_mux : 32'd0;
    wr_ack_d  = wr_acc;
    wr_err_d  = wr_acc & ~wr_ok;
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign regs_req_stall_rd = stall;
  assign regs_req_stall_wr = stall;
  assign regs_rd_ack       = rd_ack_q;
  assign regs_rd_err       = rd_err_q;
  assign regs_rd_data      = rd_data_q;
  assign regs_wr_ack       = wr_ack_q;
  assign regs_wr_err       = wr_err_q;

endmodule

// File: tb/tb_hsv_core_ctrlstatus_counters.sv
// Bench for hsv_core_ctrlstatus_counters: directed vector table, hand sequences
// and random traffic against a cycle-level reference model of the CSR rules.
module tb_hsv_core_ctrlstatus_counters;

`ifdef HSV_CTRLSTATUS_COUNTERS_INHIBIT_EN
  localparam bit INH_EN = 1'b1;
`else
  localparam bit INH_EN = 1'b0;
`endif

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic        regs_req = 1'b0;
  logic        regs_req_is_wr = 1'b0;
  logic [15:0] regs_addr = '0;
  logic [31:0] regs_wr_data = '0;
  logic [31:0] regs_wr_biten = '0;
  logic        retire = 1'b0;
  logic        regs_req_stall_rd, regs_req_stall_wr;
  logic        regs_rd_ack, regs_rd_err, regs_wr_ack, regs_wr_err;
  logic [31:0] regs_rd_data;

  int tests = 0;
  int fails = 0;

  hsv_core_ctrlstatus_counters dut (
    .clk_core          (clk_core),
    .rst_core          (rst_core),
    .regs_req          (regs_req),
    .regs_req_is_wr    (regs_req_is_wr),
    .regs_addr         (regs_addr),
    .regs_wr_data      (regs_wr_data),
    .regs_wr_biten     (regs_wr_biten),
    .regs_req_stall_rd (regs_req_stall_rd),
    .regs_req_stall_wr (regs_req_stall_wr),
    .regs_rd_ack       (regs_rd_ack),
    .regs_rd_err       (regs_rd_err),
    .regs_rd_data      (regs_rd_data),
    .regs_wr_ack       (regs_wr_ack),
    .regs_wr_err       (regs_wr_err),
    .retire            (retire)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got hang, expected $finish)");
    $fatal(1);
  end

  // Reference model: architectural counter values and the expected registered response.
  logic [63:0] m_cyc, m_ins;
  logic        m_cy, m_ir, m_pend;
  logic        e_rd_ack, e_rd_err, e_wr_ack, e_wr_err;
  logic [31:0] e_rd_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] wd,
                                      input logic [31:0] be);
    return (old & ~be) | (wd & be);
  endfunction

  task automatic model_reset();
    m_cyc = '0; m_ins = '0; m_cy = 1'b0; m_ir = 1'b0; m_pend = 1'b0;
    e_rd_ack = 1'b0; e_rd_err = 1'b0; e_wr_ack = 1'b0; e_wr_err = 1'b0; e_rd_data = '0;
  endtask

  // Advance model and DUT by one clock with the currently driven inputs, then compare.
  task automatic step();
    logic [11:0] n;
    logic        acc, mapped, rd_ok, wr_ok;
    logic [31:0] rv;
    logic [63:0] nc, ni;
    logic        ncy, nir;
    n      = regs_addr[15:4];
    mapped = n inside {12'hB00, 12'hB80, 12'hB02, 12'hB82,
                       12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h320};
    rd_ok  = mapped && (regs_addr[3:0] == 4'd0);
    wr_ok  = rd_ok && (n[11:8] != 4'hC);
    acc    = regs_req && !m_pend;
    case (n)
      12'hB00, 12'hC00: rv = m_cyc[31:0];
      12'hB80, 12'hC80: rv = m_cyc[63:32];
      12'hB02, 12'hC02: rv = m_ins[31:0];
      12'hB82, 12'hC82: rv = m_ins[63:32];
      12'h320:          rv = INH_EN ? {29'd0, m_ir, 1'b0, m_cy} : 32'd0;
      default:          rv = 32'd0;
    endcase
    e_rd_ack  = acc && !regs_req_is_wr;
    e_rd_err  = e_rd_ack && !rd_ok;
    e_rd_data = (e_rd_ack && rd_ok) ? rv : 32'd0;
    e_wr_ack  = acc && regs_req_is_wr;
    e_wr_err  = e_wr_ack && !wr_ok;
    nc  = (INH_EN && m_cy) ? m_cyc : m_cyc + 64'd1;
    ni  = (retire && !(INH_EN && m_ir)) ? m_ins + 64'd1 : m_ins;
    ncy = m_cy;
    nir = m_ir;
    if (e_wr_ack && wr_ok) begin
      case (n)
        12'hB00: nc = {m_cyc[63:32], mrg(m_cyc[31:0], regs_wr_data, regs_wr_biten)};
        12'hB80: nc = {mrg(m_cyc[63:32], regs_wr_data, regs_wr_biten), m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], mrg(m_ins[31:0], regs_wr_data, regs_wr_biten)};
        12'hB82: ni = {mrg(m_ins[63:32], regs_wr_data, regs_wr_biten), m_ins[31:0]};
        12'h320: if (INH_EN) begin
          ncy = regs_wr_biten[0] ? regs_wr_data[0] : m_cy;
          nir = regs_wr_biten[2] ? regs_wr_data[2] : m_ir;
        end
        default: ;
      endcase
    end
    m_cyc = nc; m_ins = ni; m_cy = ncy; m_ir = nir; m_pend = acc;
    @(posedge clk_core);
    #1;
    chk("rd_ack", regs_rd_ack, e_rd_ack);
    chk("rd_err", regs_rd_err, e_rd_err);
    chk("wr_ack", regs_wr_ack, e_wr_ack);
    chk("wr_err", regs_wr_err, e_wr_err);
    chk("stall_rd", regs_req_stall_rd, m_pend);
    chk("stall_wr", regs_req_stall_wr, m_pend);
    if (e_rd_ack) chk("rd_data", regs_rd_data, e_rd_data);
  endtask

  task automatic drive(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [31:0] be, input logic ret);
    regs_req = 1'b1; regs_req_is_wr = wr; regs_addr = addr;
    regs_wr_data = wd; regs_wr_biten = be; retire = ret;
  endtask

  task automatic idle(input logic ret);
    regs_req = 1'b0; regs_req_is_wr = 1'b0; regs_addr = '0;
    regs_wr_data = '0; regs_wr_biten = '0; retire = ret;
  endtask

  // One request cycle followed by one response cycle; checks read data against exp.
  task automatic xact(input string name, input logic wr, input logic [15:0] addr,
                      input logic [31:0] wd, input logic ret, input logic [31:0] exp);
    drive(wr, addr, wd, 32'hFFFF_FFFF, ret);
    step();
    if (!wr) chk(name, regs_rd_data, exp);
    idle(1'b0);
    step();
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] be;
    logic        ret;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[17];
  int   acks;

  initial begin
    tbl[0]  = '{1'b0, 16'hB000, 32'h0,         32'h0,         1'b0, 1'b0, 32'd10};
    tbl[1]  = '{1'b0, 16'hB800, 32'h0,         32'h0,         1'b0, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 16'hB000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 16'hC800, 32'h0,         32'h0,         1'b0, 1'b0, 32'd1};
    tbl[4]  = '{1'b0, 16'hB000, 32'h0,         32'h0,         1'b0, 1'b0, 32'd2};
    tbl[5]  = '{1'b1, 16'hC020, 32'h1234,      32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0};
    tbl[6]  = '{1'b0, 16'hB020, 32'h0,         32'h0,         1'b0, 1'b0, 32'd0};
    tbl[7]  = '{1'b0, 16'h7C00, 32'h0,         32'h0,         1'b0, 1'b1, 32'd0};
    tbl[8]  = '{1'b0, 16'hB001, 32'h0,         32'h0,         1'b0, 1'b1, 32'd0};
    tbl[9]  = '{1'b1, 16'hB020, 32'h100,       32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0};
    tbl[10] = '{1'b0, 16'hB020, 32'h0,         32'h0,         1'b0, 1'b0, 32'h100};
    tbl[11] = '{1'b1, 16'hB820, 32'hABCD_0000, 32'hFFFF_0000, 1'b0, 1'b0, 32'd0};
    tbl[12] = '{1'b0, 16'hC820, 32'h0,         32'h0,         1'b0, 1'b0, 32'hABCD_0000};
    tbl[13] = '{1'b0, 16'hC020, 32'h0,         32'h0,         1'b1, 1'b0, 32'h100};
    tbl[14] = '{1'b0, 16'hB020, 32'h0,         32'h0,         1'b0, 1'b0, 32'h101};
    tbl[15] = '{1'b1, 16'h3200, 32'h5,         32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0};
    tbl[16] = '{1'b0, 16'h3200, 32'h0,         32'h0,         1'b0, 1'b0, INH_EN ? 32'd5 : 32'd0};

    // Reset state
    model_reset();
    @(posedge clk_core);
    #1;
    chk("reset rd_ack", regs_rd_ack, 0);
    chk("reset rd_err", regs_rd_err, 0);
    chk("reset rd_data", regs_rd_data, 0);
    chk("reset wr_ack", regs_wr_ack, 0);
    chk("reset wr_err", regs_wr_err, 0);
    chk("reset stall", {regs_req_stall_rd, regs_req_stall_wr}, 0);
    rst_core = 1'b0;

    for (int i = 0; i < 10; i++) step();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].ret);
      step();
      if (tbl[i].wr) begin
        chk($sformatf("vec%0d wr_ack", i), regs_wr_ack, 1);
        chk($sformatf("vec%0d wr_err", i), regs_wr_err, tbl[i].err);
      end else begin
        chk($sformatf("vec%0d rd_ack", i), regs_rd_ack, 1);
        chk($sformatf("vec%0d rd_err", i), regs_rd_err, tbl[i].err);
        chk($sformatf("vec%0d rd_data", i), regs_rd_data, tbl[i].data);
      end
      idle(1'b0);
      step();
    end

    // Inhibit freeze (mcountinhibit = 5 from the table) then release
    xact("clr mcycleh", 1'b1, 16'hB800, 32'h0, 1'b0, 32'h0);
    xact("clr mcycle", 1'b1, 16'hB000, 32'h0, 1'b0, 32'h0);
    xact("clr minstreth", 1'b1, 16'hB820, 32'h0, 1'b0, 32'h0);
    xact("clr minstret", 1'b1, 16'hB020, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin idle(1'b1); step(); end
    xact("inhibit mcycle", 1'b0, 16'hB000, 32'h0, 1'b0, INH_EN ? 32'd0 : 32'd9);
    xact("inhibit minstret", 1'b0, 16'hB020, 32'h0, 1'b0, INH_EN ? 32'd0 : 32'd4);
    xact("clr inhibit", 1'b1, 16'h3200, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin idle(1'b1); step(); end
    xact("minstret +3", 1'b0, 16'hB020, 32'h0, 1'b0, INH_EN ? 32'd3 : 32'd7);

    // Request held across the stall: one ack per acceptance, none while stalled
    acks = 0;
    drive(1'b0, 16'hB000, 32'h0, 32'h0, 1'b0);
    step(); acks += int'(regs_rd_ack);
    chk("hold stall in ack cycle", regs_req_stall_rd, 1);
    step(); acks += int'(regs_rd_ack);
    chk("hold one ack over 2 cycles", acks, 1);
    chk("hold stall dropped", regs_req_stall_rd, 0);
    step();
    chk("hold second acceptance", regs_rd_ack, 1);
    idle(1'b0);
    step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] addrs [11];
      logic [31:0] wd;
      addrs = '{16'hB000, 16'hB800, 16'hB020, 16'hB820, 16'hC000, 16'hC800,
                16'hC020, 16'hC820, 16'h3200, 16'h7C00, 16'hB008};
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: wd = $urandom;
      endcase
      if ($urandom_range(0, 2) == 0)
        drive(1'b1 & $urandom_range(0, 1), addrs[$urandom_range(0, 10)], wd,
              ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom_range(0, 1)));
      else
        idle(1'($urandom_range(0, 1)));
      step();
    end
    idle(1'b0);
    step();

    // Reset with a response pending: ack dropped, counters cleared
    drive(1'b1, 16'hB000, 32'h55, 32'hFFFF_FFFF, 1'b0);
    step();
    idle(1'b0);
    #2;
    rst_core = 1'b1;
    #1;
    chk("midreset wr_ack", regs_wr_ack, 0);
    chk("midreset stall", regs_req_stall_wr, 0);
    model_reset();
    @(posedge clk_core);
    #1;
    rst_core = 1'b0;
    for (int i = 0; i < 3; i++) step();
    xact("post reset mcycle", 1'b0, 16'hB000, 32'h0, 1'b0, 32'd3);
    xact("post reset minstret", 1'b0, 16'hB020, 32'h0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
